// File: rtl/div_issue_ctrl_if.sv
// Bundle of the request, divider and result channels of div_issue_ctrl.
// master: the issue controller. slave: the pipeline/divider around it.
// Valid/ready: a transfer happens on a rising clk edge where valid and
// ready are both high. A producer holds valid and payload stable until
// that edge. flush overrides every transfer in the same cycle.
interface div_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_word;
    logic [63:0]      in_src1;
    logic [63:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             div_valid;
    logic [63:0]      div_a;
    logic [63:0]      div_b;
    logic             div_signed;
    logic             div_flush;
    logic             div_result_valid;
    logic [63:0]      div_quotient;
    logic [63:0]      div_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        input  flush, in_valid, in_op, in_word, in_src1, in_src2, in_tag,
        input  div_result_valid, div_quotient, div_remainder, out_ready,
        output in_ready, div_valid, div_a, div_b, div_signed, div_flush,
        output out_valid, out_result, out_tag
    );

    modport slave (
        output flush, in_valid, in_op, in_word, in_src1, in_src2, in_tag,
        output div_result_valid, div_quotient, div_remainder, out_ready,
        input  in_ready, div_valid, div_a, div_b, div_signed, div_flush,
        input  out_valid, out_result, out_tag
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue controller for a variable-latency 64-bit divider. Accepts one
// DIV/DIVU/REM/REMU (optionally W) request, launches the divider, selects
// quotient or remainder, fixes up divide-by-zero and signed overflow, and
// holds the result until the consumer takes it.
// Optional feature macro: DIV_FAST_PATH_EN -- divide-by-zero and signed
// overflow requests skip the divider and complete the cycle after accept.
module div_issue_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    div_issue_ctrl_if.master bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] tag_q;
    logic [1:0]       op_q;
    logic             word_q;
    logic             signed_q;
    logic [63:0]      a_q, b_q, result_q;
    logic             accept;
    logic [63:0]      ext_a, ext_b;

    // W forms widen src[31:0]; unsigned ops zero-extend, signed ops sign-extend.
    function automatic logic [63:0] extend(input logic [63:0] v, input logic word, input logic sgn);
        if (!word) return v;
        if (sgn) return {{32{v[31]}}, v[31:0]};
        return {32'b0, v[31:0]};
    endfunction

    // Most-negative dividend as it appears after extension.
    function automatic logic [63:0] most_neg(input logic word);
        return word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    endfunction

    // Pick quotient/remainder, override the divider for /0 and overflow,
    // and sign-extend bit 31 for W forms.
    function automatic logic [63:0] finalize(input logic [1:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] q, input logic [63:0] r);
        logic [63:0] qs, rs, sel;
        qs = q;
        rs = r;
        if (b == 64'd0) begin
            qs = '1;
            rs = a;
        end else if (!op[0] && a == most_neg(word) && b == '1) begin
            qs = a;
            rs = '0;
        end
        sel = op[1] ? rs : qs;
        if (word) sel = {{32{sel[31]}}, sel[31:0]};
        return sel;
    endfunction

`ifdef DIV_FAST_PATH_EN
    logic fast_special;

    function automatic logic is_special(input logic [63:0] a, input logic [63:0] b,
                                        input logic sgn, input logic word);
        return (b == 64'd0) || (sgn && a == most_neg(word) && b == '1);
    endfunction

    assign fast_special = is_special(ext_a, ext_b, !bus.in_op[0], bus.in_word);
`endif

    assign accept = bus.in_valid && (state_q == IDLE) && !bus.flush;
    assign ext_a  = extend(bus.in_src1, bus.in_word, !bus.in_op[0]);
    assign ext_b  = extend(bus.in_src2, bus.in_word, !bus.in_op[0]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state; flush returns to IDLE from anywhere and beats every other event.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef DIV_FAST_PATH_EN
                    state_d = fast_special ? DONE : LAUNCH;
`else
                    state_d = LAUNCH;
`endif
                end
            end
            LAUNCH:  state_d = WAIT;
            WAIT:    if (bus.div_result_valid) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush) state_d = IDLE;
    end

    // Request capture and result capture; operands stay put until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            signed_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                tag_q    <= bus.in_tag;
                op_q     <= bus.in_op;
                word_q   <= bus.in_word;
                signed_q <= !bus.in_op[0];
                a_q      <= ext_a;
                b_q      <= ext_b;
`ifdef DIV_FAST_PATH_EN
                if (fast_special)
                    result_q <= finalize(bus.in_op, bus.in_word, ext_a, ext_b, '0, '0);
`endif
            end
            if (state_q == WAIT && bus.div_result_valid && !bus.flush)
                result_q <= finalize(op_q, word_q, a_q, b_q, bus.div_quotient, bus.div_remainder);
            if (bus.flush)
                result_q <= '0;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.div_valid  = (state_q == LAUNCH) && !bus.flush;
    assign bus.div_a      = a_q;
    assign bus.div_b      = b_q;
    assign bus.div_signed = signed_q;
    assign bus.div_flush  = bus.flush;
    assign bus.out_valid  = (state_q == DONE) && !bus.flush;
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed requests, a variable-latency divider
// responder, and a behavioural result model with a scoreboard queue.
module tb_div_issue_ctrl;
    localparam int TAG_W = 5;

    logic clk;
    logic reset;
    logic [1:0] dbg_state;
    logic main_flush, resp_flush, resp_rv, spur_rv, flush_on_result;
    int   checks, errors, launch_cnt, resp_done, div_lat;
    logic [63:0] exp_a, exp_b;
    logic        exp_s;
    logic [63:0] r_a, r_b, r_q, r_r;
    logic        r_s, aborted;
    logic [63:0]      exp_q[$];
    logic [TAG_W-1:0] exp_tag_q[$];

    div_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    div_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_state_o(dbg_state)
    );

    assign bus.flush            = main_flush | resp_flush;
    assign bus.div_result_valid = resp_rv | spur_rv;

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result from the op rules, W forms computed in 32 bits.
    function automatic logic [63:0] model_result(input logic [1:0] op, input logic w,
                                                 input logic [63:0] x, input logic [63:0] y);
        logic [63:0] q, r;
        logic [31:0] a32, b32, q32, r32;
        a32 = x[31:0];
        b32 = y[31:0];
        q32 = '0; r32 = '0; q = '0; r = '0;
        if (w) begin
            if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
            else if (op[0]) begin q32 = a32 / b32; r32 = a32 % b32; end
            else begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            return op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        if (y == 64'd0) begin q = '1; r = x; end
        else if (!op[0] && x == 64'h8000_0000_0000_0000 && y == '1) begin q = x; r = '0; end
        else if (op[0]) begin q = x / y; r = x % y; end
        else begin q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); end
        return op[1] ? r : q;
    endfunction

    function automatic logic [63:0] widen(input logic [63:0] v, input logic w, input logic sgn);
        if (!w) return v;
        return sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
    endfunction

    function automatic logic special_case(input logic [1:0] op, input logic w,
                                          input logic [63:0] x, input logic [63:0] y);
        if (w) return (y[31:0] == 32'd0) ||
                      (!op[0] && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
        return (y == 64'd0) || (!op[0] && x == 64'h8000_0000_0000_0000 && y == '1);
    endfunction

    // Divider responder: checks the launch, waits div_lat cycles, returns a result.
    // Special cases get junk so the controller's own substitution is exercised.
    initial begin
        resp_rv = 1'b0;
        resp_flush = 1'b0;
        bus.div_quotient = '0;
        bus.div_remainder = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.div_valid) begin
                launch_cnt++;
                r_a = bus.div_a; r_b = bus.div_b; r_s = bus.div_signed;
                check("div_a", r_a, exp_a);
                check("div_b", r_b, exp_b);
                check("div_signed", {63'd0, r_s}, {63'd0, exp_s});
                aborted = 1'b0;
                for (int i = 0; i < div_lat; i++) begin
                    @(negedge clk);
                    if (reset || bus.div_flush) begin aborted = 1'b1; break; end
                    check("div_valid_single", {63'd0, bus.div_valid}, 64'd0);
                    check("div_a_hold", bus.div_a, exp_a);
                    check("div_b_hold", bus.div_b, exp_b);
                end
                if (!aborted) begin
                    if (r_b == 64'd0 || (r_s && r_a == 64'h8000_0000_0000_0000 && r_b == '1)) begin
                        r_q = 64'hDEAD_0000_0000_0001; r_r = 64'hDEAD_0000_0000_0002;
                    end else if (r_s) begin
                        r_q = $signed(r_a) / $signed(r_b); r_r = $signed(r_a) % $signed(r_b);
                    end else begin
                        r_q = r_a / r_b; r_r = r_a % r_b;
                    end
                    @(posedge clk); #1;
                    bus.div_quotient = r_q; bus.div_remainder = r_r;
                    resp_rv = 1'b1; resp_flush = flush_on_result;
                    @(posedge clk); #1;
                    resp_rv = 1'b0; resp_flush = 1'b0;
                end
                resp_done++;
            end
        end
    end

    // Scoreboard: whenever a result is offered it must be the oldest expected one.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_out_valid: got out_valid=1 expected 0 at %0t", $time);
            end else begin
                check("out_result", bus.out_result, exp_q[0]);
                check("out_tag", {59'd0, bus.out_tag}, {59'd0, exp_tag_q[0]});
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_tag_q.pop_front());
                end
            end
        end
    end

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [TAG_W-1:0] tag, input int lat);
        int n;
        exp_a = widen(s1, w, !op[0]);
        exp_b = widen(s2, w, !op[0]);
        exp_s = !op[0];
        div_lat = lat;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_word = w;
        bus.in_src1 = s1; bus.in_src2 = s2; bus.in_tag = tag;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin check("accept_timeout", 64'd0, 64'd1); break; end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from accept to the first out_valid; 0 on timeout.
    task automatic wait_out(output int n);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin n = i; break; end
        end
        if (n == 0) begin
            check("out_valid_timeout", 64'd0, 64'd1);
            exp_q.delete(); exp_tag_q.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] s1,
                          input logic [63:0] s2, input logic [TAG_W-1:0] tag, input int lat,
                          input int hold, input logic pin, input logic [63:0] lit);
        int n, l0;
        logic [63:0] m;
        logic spc;
        m = model_result(op, w, s1, s2);
        spc = special_case(op, w, s1, s2);
        if (pin) check("model_pin", m, lit);
        exp_q.push_back(m);
        exp_tag_q.push_back(tag);
        l0 = launch_cnt;
        issue(op, w, s1, s2, tag, lat);
        wait_out(n);
        if (n == 0) return;
`ifdef DIV_FAST_PATH_EN
        if (spc) begin
            check("fast_latency", n, 1);
            check("fast_no_launch", launch_cnt - l0, 0);
        end else begin
            check("launch_count", launch_cnt - l0, 1);
        end
`else
        check("launch_count", launch_cnt - l0 + (spc ? 0 : 0), 1);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("ready_after_retire", {63'd0, bus.in_ready}, 64'd1);
        check("retired", exp_q.size(), 0);
    endtask

    task automatic idle_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check(name, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
        end
    endtask

    // Main sequence.
    initial begin
        int n, d0;
        checks = 0; errors = 0; launch_cnt = 0; resp_done = 0; div_lat = 0;
        exp_a = '0; exp_b = '0; exp_s = 1'b0;
        reset = 1'b1; main_flush = 1'b0; spur_rv = 1'b0; flush_on_result = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_word = 1'b0;
        bus.in_src1 = '0; bus.in_src2 = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_div_valid", {63'd0, bus.div_valid}, 64'd0);
        check("rst_out_result", bus.out_result, 64'd0);
        check("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
        check("rst_div_a", bus.div_a, 64'd0);
        check("rst_div_b", bus.div_b, 64'd0);

        run_op(2'b01, 1'b0, 64'd100, 64'd7, 5'd3, 4, 0, 1'b1, 64'd14);
        run_op(2'b11, 1'b0, 64'd100, 64'd7, 5'd4, 0, 0, 1'b1, 64'd2);
        run_op(2'b00, 1'b0, -64'sd7, 64'd2, 5'd5, 1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 1'b0, -64'sd7, 64'd2, 5'd6, 7, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b00, 1'b0, 64'd5, 64'd0, 5'd7, 3, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b10, 1'b0, 64'd5, 64'd0, 5'd8, 2, 0, 1'b1, 64'd5);
        run_op(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd9, 5, 0, 1'b1, 64'hFFFF_FFFF_8000_0000);
        run_op(2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd10, 2, 0, 1'b1, 64'd0);
        run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd11, 3, 0, 1'b1, 64'h8000_0000_0000_0000);
        run_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd12, 1, 0, 1'b1, 64'd0);
        run_op(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd3, 5'd13, 6, 0, 1'b1, 64'h0000_0000_5555_5550);
        run_op(2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14, 2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b01, 1'b1, 64'd77, 64'hABCD_0000_0000_0000, 5'd15, 2, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b11, 1'b1, 64'h1_8000_0001, 64'h5_0000_0000, 5'd16, 3, 0, 1'b1, 64'hFFFF_FFFF_8000_0001);
        run_op(2'b01, 1'b0, 64'd1000, 64'd10, 5'd17, 9, 5, 1'b1, 64'd100);

        // flush 20 cycles into WAIT
        issue(2'b01, 1'b0, 64'd50, 64'd5, 5'd18, 40);
        repeat (21) @(posedge clk);
        #1 main_flush = 1'b1;
        @(negedge clk);
        check("flush_div_flush", {63'd0, bus.div_flush}, 64'd1);
        check("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        @(posedge clk); #1 main_flush = 1'b0;
        idle_quiet("after_wait_flush", 4);
        run_op(2'b01, 1'b0, 64'd9, 64'd3, 5'd19, 3, 0, 1'b1, 64'd3);

        // flush on the same cycle as the divider result
        flush_on_result = 1'b1;
        d0 = resp_done;
        issue(2'b00, 1'b0, 64'd20, 64'd3, 5'd20, 3);
        for (int i = 0; i < 100 && resp_done == d0; i++) @(negedge clk);
        flush_on_result = 1'b0;
        check("result_flush_done", resp_done - d0, 1);
        idle_quiet("after_result_flush", 4);

        // flush on the same cycle as out_ready
        exp_q.push_back(model_result(2'b01, 1'b0, 64'd8, 64'd2));
        exp_tag_q.push_back(5'd21);
        issue(2'b01, 1'b0, 64'd8, 64'd2, 5'd21, 1);
        wait_out(n);
        @(posedge clk); #1;
        main_flush = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("ready_flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("ready_flush_div_flush", {63'd0, bus.div_flush}, 64'd1);
        @(posedge clk); #1;
        main_flush = 1'b0; bus.out_ready = 1'b0;
        if (exp_q.size() != 0) begin void'(exp_q.pop_front()); void'(exp_tag_q.pop_front()); end
        idle_quiet("after_ready_flush", 4);

        // divider done pulse while IDLE is ignored
        @(posedge clk); #1 spur_rv = 1'b1;
        @(posedge clk); #1 spur_rv = 1'b0;
        idle_quiet("stray_result", 3);
        run_op(2'b00, 1'b0, 64'd1000, -64'sd9, 5'd22, 2, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FF91);

        // reset in the middle of an operation
        issue(2'b00, 1'b0, 64'd1234, 64'd7, 5'd23, 30);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_out_result", bus.out_result, 64'd0);
        check("midrst_out_tag", {59'd0, bus.out_tag}, 64'd0);
        check("midrst_div_a", bus.div_a, 64'd0);
        idle_quiet("after_midrst", 3);
        run_op(2'b11, 1'b0, 64'd1234, 64'd7, 5'd24, 4, 0, 1'b1, 64'd2);

        check("queue_empty_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, giving the destination-tag width.
REQ-002 SHALL have one clock and a synchronous active-high reset, with the ports below.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline kill
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when high with in_valid
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- in_word  in  1  32-bit W variant
- in_src1  in  64  dividend
- in_src2  in  64  divisor
- in_tag  in  TAG_W  destination tag
- div_valid  out  1  divider start pulse
- div_a  out  64  divider dividend
- div_b  out  64  divider divisor
- div_signed  out  1  divider signed mode
- div_flush  out  1  divider kill
- div_result_valid  in  1  divider done pulse
- div_quotient  in  64  divider quotient
- div_remainder  in  64  divider remainder
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  64  final result
- out_tag  out  TAG_W  tag of the result

Function
REQ-003 SHALL implement FSM states IDLE, LAUNCH, WAIT and DONE.
REQ-004 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid&&in_ready&&!flush.
REQ-005 On accept, SHALL register tag, op and operands; W ops sign-extend (DIV/REM) or zero-extend (DIVU/REMU) src[31:0] to 64 bits; div_signed = !op[0].
REQ-006 Normal path: accept -> LAUNCH; in LAUNCH, div_valid=1 for exactly one cycle; next state WAIT.
REQ-007 div_a, div_b and div_signed SHALL be driven from registers and held constant from LAUNCH until the cycle div_result_valid is seen, because the divider applies sign correction combinationally at its output.
REQ-008 In WAIT, on div_result_valid, SHALL capture quotient (op[1]=0) or remainder (op[1]=1) and go to DONE; latency SHALL NOT depend on a fixed divider cycle count.
REQ-009 W ops: out_result = sign-extension of the selected value [31:0], for all four W ops.
REQ-010 Divide by zero (extended divisor==0): quotient = all ones; remainder = extended dividend.
REQ-011 Signed overflow (dividend = most-negative for the width, divisor = -1): quotient = dividend; remainder = 0.
REQ-012 In DONE, out_valid=1 and out_result/out_tag SHALL be stable until out_ready; on out_ready -> IDLE.
REQ-013 flush in any state SHALL assert div_flush the same cycle, go to IDLE next cycle, drop any captured result, and drive out_valid=0 from the next cycle.
REQ-014 flush coincident with div_result_valid or out_ready: flush wins, no result is delivered.
REQ-015 div_result_valid outside WAIT SHALL be ignored.

Reset
REQ-016 On reset: state=IDLE, out_valid=0, div_valid=0, out_result=0, out_tag=0, operand registers=0; in_ready=1 in the first cycle after reset.
REQ-017 Reset mid-operation SHALL abandon the operation with no output; the divider is reset by the same reset.

Configuration
REQ-018 SHALL provide macro DIV_FAST_PATH_EN.
REQ-019 With DIV_FAST_PATH_EN defined: REQ-010/011 cases go IDLE->DONE directly, div_valid is never asserted, and out_valid is high the cycle after accept.
REQ-020 Without DIV_FAST_PATH_EN: all ops take the divider path, and the REQ-010/011 results are substituted at capture (REQ-008).

Verification
REQ-021 DIVU 100/7 -> out_result 14; REMU -> 2; tag echoed.
REQ-022 DIV -7/2 -> 0xFFFFFFFFFFFFFFFD; REM -> 0xFFFFFFFFFFFFFFFF.
REQ-023 DIV 5/0 -> 0xFFFFFFFFFFFFFFFF; REM 5/0 -> 5; with the macro: out_valid 1 cycle after accept and no div_valid.
REQ-024 DIVW 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000; REMW -> 0.
REQ-025 flush 20 cycles into WAIT -> div_flush pulse, no out_valid, in_ready=1 next cycle; then DIVU 9/3 -> 3.
REQ-026 out_ready held low 5 cycles in DONE -> out_result and out_tag stable and in_ready=0; result retires on the first out_ready.
